blink_monitor: RTL and testbench

BLINK_MONITOR -- requirements
Module: blink_monitor

---
 rtl/blink_monitor.sv | 142 ++++++++++++++
 tb/tb_blink_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/blink_monitor.sv
// Measures high/low durations of an asynchronous blink waveform, one full period at a time,
// and hands each result to a consumer through a valid/ack handshake.
module blink_monitor #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PER_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             ack,
  output logic             valid,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [PER_W-1:0] periods,
  output logic             overrun,
  output logic             timeout
);

  typedef enum logic [1:0] {StSync, StHigh, StLow} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [PER_W-1:0] PerOne = PER_W'(1);

  state_e           state_q, state_d;
  logic             sync1_q, in_s_q, prev_q;
  logic [2:0]       warm_q, warm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hi_tmp_q, hi_tmp_d;
  logic [CNT_W-1:0] high_len_q, high_len_d, low_len_q, low_len_d;
  logic [PER_W-1:0] periods_q, periods_d;
  logic             valid_q, valid_d, overrun_q, overrun_d, timeout_q, timeout_d;
  logic             rise, fall, sat, complete;

  // Reset zeros in the synchronizer are not observations of in; a rise only counts once
  // prev holds a genuine sample, so a line already high at reset release is ignored.
  assign rise = in_s_q & ~prev_q & warm_q[2];
  assign fall = ~in_s_q & prev_q;
  assign sat  = (cnt_q == '1);

  always_comb begin
    state_d    = state_q;
    warm_d     = {warm_q[1:0], 1'b1};
    cnt_d      = cnt_q;
    hi_tmp_d   = hi_tmp_q;
    high_len_d = high_len_q;
    low_len_d  = low_len_q;
    periods_d  = periods_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;
    complete   = 1'b0;

    case (state_q)
      StSync: begin
        if (rise) begin
          state_d = StHigh;
          cnt_d   = CntOne;
        end
      end
      StHigh: begin
        if (fall) begin
          hi_tmp_d = cnt_q;
          cnt_d    = CntOne;
          state_d  = StLow;
        end else if (sat) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StSync;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StLow: begin
        if (rise) begin
          complete = 1'b1;
          cnt_d    = CntOne;
          state_d  = StHigh;
        end else if (sat) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StSync;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StSync;
    endcase

    if (valid_q && ack) valid_d = 1'b0;

    // A completion loads only if the slot is free or being freed this cycle.
    if (complete) begin
      periods_d = periods_q + PerOne;
      if (!valid_q || ack) begin
        high_len_d = hi_tmp_q;
        low_len_d  = cnt_q;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StSync;
      sync1_q    <= 1'b0;
      in_s_q     <= 1'b0;
      prev_q     <= 1'b0;
      warm_q     <= '0;
      cnt_q      <= '0;
      hi_tmp_q   <= '0;
      high_len_q <= '0;
      low_len_q  <= '0;
      periods_q  <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= in;
      in_s_q     <= sync1_q;
      prev_q     <= in_s_q;
      warm_q     <= warm_d;
      cnt_q      <= cnt_d;
      hi_tmp_q   <= hi_tmp_d;
      high_len_q <= high_len_d;
      low_len_q  <= low_len_d;
      periods_q  <= periods_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign valid    = valid_q;
  assign high_len = high_len_q;
  assign low_len  = low_len_q;
  assign periods  = periods_q;
  assign overrun  = overrun_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor: default-width instance plus a 4-bit-counter instance
// for the saturation case.
module tb_blink_monitor;

  logic        clk, reset, in, ack, in4, ack4;
  logic        valid, overrun, timeout, valid4, overrun4, timeout4;
  logic [15:0] high_len, low_len, periods;
  logic [3:0]  high_len4, low_len4;
  logic [3:0]  periods4;
  int          checks = 0;
  int          errors = 0;

  blink_monitor dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .ack      (ack),
    .valid    (valid),
    .high_len (high_len),
    .low_len  (low_len),
    .periods  (periods),
    .overrun  (overrun),
    .timeout  (timeout)
  );

  blink_monitor #(.CNT_W(4), .PER_W(4)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .in       (in4),
    .ack      (ack4),
    .valid    (valid4),
    .high_len (high_len4),
    .low_len  (low_len4),
    .periods  (periods4),
    .overrun  (overrun4),
    .timeout  (timeout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic lvl);
    in    = lvl;
    in4   = 1'b0;
    ack   = 1'b0;
    ack4  = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(4);
  endtask

  initial begin
    reset = 1'b1; in = 1'b0; ack = 1'b0; in4 = 1'b0; ack4 = 1'b0;
    step(2);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_high", 32'(high_len), 32'd0);
    chk("rst_low", 32'(low_len), 32'd0);
    chk("rst_periods", 32'(periods), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // 5/5 square wave, ack tied high
    do_reset(1'b0);
    ack = 1'b1;
    in = 1'b1; step(5);
    in = 1'b0; step(5);
    in = 1'b1; step(3);
    chk("sq_valid1", 32'(valid), 32'd1);
    chk("sq_high1", 32'(high_len), 32'd5);
    chk("sq_low1", 32'(low_len), 32'd5);
    chk("sq_per1", 32'(periods), 32'd1);
    step(1);
    chk("sq_valid_pulse", 32'(valid), 32'd0);
    step(1);
    in = 1'b0; step(5);
    in = 1'b1; step(3);
    chk("sq_valid2", 32'(valid), 32'd1);
    chk("sq_high2", 32'(high_len), 32'd5);
    chk("sq_low2", 32'(low_len), 32'd5);
    chk("sq_per2", 32'(periods), 32'd2);

    // 3/7 then 4/6 with ack held low: second result dropped
    do_reset(1'b0);
    in = 1'b1; step(3);
    in = 1'b0; step(7);
    in = 1'b1; step(3);
    chk("ov_valid1", 32'(valid), 32'd1);
    chk("ov_high1", 32'(high_len), 32'd3);
    chk("ov_low1", 32'(low_len), 32'd7);
    chk("ov_per1", 32'(periods), 32'd1);
    chk("ov_overrun1", 32'(overrun), 32'd0);
    step(1);
    in = 1'b0; step(6);
    in = 1'b1; step(3);
    chk("ov_valid2", 32'(valid), 32'd1);
    chk("ov_high2", 32'(high_len), 32'd3);
    chk("ov_low2", 32'(low_len), 32'd7);
    chk("ov_per2", 32'(periods), 32'd2);
    chk("ov_overrun2", 32'(overrun), 32'd1);

    // same, but ack lands in the completing cycle of the second period
    do_reset(1'b0);
    in = 1'b1; step(3);
    in = 1'b0; step(7);
    in = 1'b1; step(4);
    in = 1'b0; step(6);
    in = 1'b1; step(2);
    ack = 1'b1; step(1);
    ack = 1'b0;
    chk("ak_valid", 32'(valid), 32'd1);
    chk("ak_high", 32'(high_len), 32'd4);
    chk("ak_low", 32'(low_len), 32'd6);
    chk("ak_per", 32'(periods), 32'd2);
    chk("ak_overrun", 32'(overrun), 32'd0);
    step(1);
    chk("ak_valid_hold", 32'(valid), 32'd1);

    // 4-bit counter saturates on a 20-cycle high, then a 2/2 period measures cleanly
    do_reset(1'b0);
    in4 = 1'b1; step(20);
    chk("to_timeout", 32'(timeout4), 32'd1);
    chk("to_novalid", 32'(valid4), 32'd0);
    in4 = 1'b0; step(5);
    in4 = 1'b1; step(2);
    in4 = 1'b0; step(2);
    in4 = 1'b1; step(3);
    chk("to_valid", 32'(valid4), 32'd1);
    chk("to_high", 32'(high_len4), 32'd2);
    chk("to_low", 32'(low_len4), 32'd2);
    chk("to_per", 32'(periods4), 32'd1);
    chk("to_sticky", 32'(timeout4), 32'd1);

    // reset mid-HIGH with in staying high across the release
    do_reset(1'b0);
    in = 1'b1; step(3);
    in = 1'b0; step(7);
    in = 1'b1; step(4);
    reset = 1'b1; step(1);
    reset = 1'b0;
    chk("mr_valid", 32'(valid), 32'd0);
    chk("mr_high", 32'(high_len), 32'd0);
    chk("mr_low", 32'(low_len), 32'd0);
    chk("mr_per", 32'(periods), 32'd0);
    step(5);
    in = 1'b0; step(5);
    in = 1'b1; step(3);
    in = 1'b0; step(5);
    chk("mr_noresult", 32'(valid), 32'd0);
    chk("mr_noper", 32'(periods), 32'd0);
    in = 1'b1; step(3);
    chk("mr_valid2", 32'(valid), 32'd1);
    chk("mr_high2", 32'(high_len), 32'd3);
    chk("mr_low2", 32'(low_len), 32'd5);
    chk("mr_per2", 32'(periods), 32'd1);

    // in already high at reset release: that first high interval is not measured
    do_reset(1'b1);
    step(6);
    in = 1'b0; step(4);
    in = 1'b1; step(2);
    in = 1'b0; step(1);
    chk("hs_novalid", 32'(valid), 32'd0);
    chk("hs_noper", 32'(periods), 32'd0);
    step(4);
    in = 1'b1; step(3);
    chk("hs_valid", 32'(valid), 32'd1);
    chk("hs_high", 32'(high_len), 32'd2);
    chk("hs_low", 32'(low_len), 32'd5);
    chk("hs_per", 32'(periods), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
